bram_tdp_be: RTL and testbench
==============================

Name: bram_tdp_be

Overview:
- Single-clock, true dual-port block RAM with per-byte write enables.
- Selectable read-during-write mode, optional output register, and per-port read-valid tracking.
- Post-reset hardware clear sweep, plus deterministic cross-port collision resolution.
- Drop-in storage for packet buffers and descriptor tables where both ports run in the core clock domain.

Parameters:
- DATA, 72, word width in bits; must be a multiple of BYTE.
- ADDR, 10, address width; depth = 2**ADDR.
- BYTE, 9, bits per write-enable lane; NBE = DATA/BYTE.
- RDW_MODE, 0, same-port read-during-write: 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 zero-fills the array after reset.

Ports:
- clk  in  1  single clock for both ports
- rst_n  in  1  synchronous active-low reset
- init_done  out  1  high once the array is usable
- a_en  in  1  port A access request
- a_wr  in  1  port A write (qualified by a_en)
- a_be  in  NBE  port A byte-lane enables
- a_addr  in  ADDR  port A address
- a_din  in  DATA  port A write data
- a_dout  out  DATA  port A read data
- a_valid  out  1  a_dout carries the result of an access
- b_en, b_wr, b_be, b_addr, b_din, b_dout, b_valid  same as port A, for port B
- collision  out  1  same-address conflict flag, one-cycle pulse

Behaviour:
- Reset: rst_n sampled low at posedge. Outputs then take these values:
  - a_dout, b_dout = 0; a_valid, b_valid = 0; collision = 0.
  - Clear counter = 0.
  - init_done = 0 if CLEAR_ON_RESET, else 1.
  - Array contents are untouched by reset itself.
- FSM states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET, else READY.
  - CLEAR: writes 0 to mem[cnt] each cycle, cnt++. After writing 2**ADDR-1, go to READY; init_done rises on the following cycle.
  - Sweep takes exactly 2**ADDR cycles.
  - Port requests during CLEAR are dropped: no write, valid stays 0.
  - Reset mid-sweep restarts from address 0.
- Access (READY, x_en=1):
  - Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); x_valid is aligned with x_dout.
  - x_en=0: no access; x_dout holds its value; x_valid=0 in the matching cycle.
  - Write updates only lanes with x_be[i]=1. A write with x_be=0 is a read.
- Same-port read-during-write:
  - WRITE_FIRST: dout = merged word (new lanes where be=1, old lanes elsewhere); valid=1.
  - READ_FIRST: dout = pre-write word; valid=1.
  - NO_CHANGE: dout holds its previous value; valid=0.
- Cross-port, same address, same cycle, both enabled:
  - Both write: port A wins per lane where both be bits are set. Lanes enabled only by B take b_din. Lanes enabled by neither keep the old value.
  - One writes, one reads: the reader returns the pre-write word, regardless of RDW_MODE.
  - Writer's own dout follows RDW_MODE using the final stored word.
  - collision=1 when both en, addresses equal, and at least one is writing. It is registered, pulsing in the cycle after the request, independent of OUT_REG.
- Address width: full range, no wrap logic. The final address 2**ADDR-1 is valid.
- The array must infer block RAM. The byte merge and priority logic live outside the array write statement.

Decomposition:
- Package bram_pkg:
  - RDW_WRITE_FIRST/RDW_READ_FIRST/RDW_NO_CHANGE constants.
  - State encoding for CLEAR/READY.
  - Function nbe(DATA,BYTE).
- Sub-module bram_port_out: optional output register plus valid alignment and NO_CHANGE hold. Instantiated once per port.

Test Plan:
Bench config: DATA=32, BYTE=8, ADDR=4, CLEAR_ON_RESET=1, OUT_REG=0 unless stated.
- Reset then idle: rst_n low 2 cycles then high -> init_done=0 for exactly 16 cycles, then 1; reads of addresses 0..15 return 0x00000000 with valid=1 one cycle later.
- Byte write: A writes 0xAABBCCDD to addr 3 with be=4'b0101 over prior 0 -> read of addr 3 returns 0x00BB00DD.
- RDW modes: addr 5 holds 0x11111111; A writes 0x22222222, be=4'hF -> a_dout is 0x22222222 (WRITE_FIRST), 0x11111111 (READ_FIRST), or held with a_valid=0 (NO_CHANGE).
- Write-write collision: A writes 0xAAAAAAAA be=4'b0011 and B writes 0xBBBBBBBB be=4'b0110 to addr 7, same cycle -> mem[7]=0x00BBAAAA; collision=1 for one cycle.
- Read/write collision: addr 9 holds 0x12345678; A writes 0xDEADBEEF while B reads addr 9 -> b_dout=0x12345678; collision=1; next B read returns 0xDEADBEEF.
- Reset mid-clear and OUT_REG=1: rst_n low at sweep cycle 6 -> sweep restarts at 0 and init_done rises 16 cycles after release; with OUT_REG=1, a read issued at cycle t has valid/data at t+2.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared constants, FSM encoding and helpers for the byte-enabled true dual-port RAM.
package bram_pkg;

  // Same-port read-during-write behaviour selectors.
  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;
  localparam int unsigned RDW_NO_CHANGE   = 2;

  // Array initialisation state.
  typedef enum logic {
    StClear = 1'b0,
    StReady = 1'b1
  } state_e;

  // Number of byte-enable lanes in a word.
  function automatic int unsigned nbe(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/bram_port_out.sv
// Per-port read output stage: optional pipeline register, valid alignment and
// hold of the last returned word when no new result is presented.
module bram_port_out #(
  parameter int unsigned DATA    = 72,
  parameter int unsigned OUT_REG = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            acc,    // an access was accepted last cycle
  input  logic            hold,   // that access must not update dout (NO_CHANGE write)
  input  logic [DATA-1:0] word,   // word the access returns
  output logic [DATA-1:0] dout,
  output logic            valid
);

  logic            show;
  logic [DATA-1:0] dout_q;
  logic            valid_q;

  assign show = acc & ~hold;

  // Remember the last presented word; doubles as the output register when OUT_REG=1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= show;
      if (show) dout_q <= word;
    end
  end

  // Select registered or bypassed presentation of the read result.
  always_comb begin
    if (OUT_REG != 0) begin
      dout  = dout_q;
      valid = valid_q;
    end else begin
      dout  = show ? word : dout_q;
      valid = show;
    end
  end

endmodule

// File: rtl/bram_tdp_be.sv
// Single-clock true dual-port RAM with byte-lane write enables, selectable
// read-during-write mode, post-reset zero sweep and port-A-priority collisions.
module bram_tdp_be import bram_pkg::*; #(
  parameter int unsigned DATA           = 72,
  parameter int unsigned ADDR           = 10,
  parameter int unsigned BYTE           = 9,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_done,
  input  logic                 a_en,
  input  logic                 a_wr,
  input  logic [DATA/BYTE-1:0] a_be,
  input  logic [ADDR-1:0]      a_addr,
  input  logic [DATA-1:0]      a_din,
  output logic [DATA-1:0]      a_dout,
  output logic                 a_valid,
  input  logic                 b_en,
  input  logic                 b_wr,
  input  logic [DATA/BYTE-1:0] b_be,
  input  logic [ADDR-1:0]      b_addr,
  input  logic [DATA-1:0]      b_din,
  output logic [DATA-1:0]      b_dout,
  output logic                 b_valid,
  output logic                 collision
);

  localparam int unsigned NBE   = nbe(DATA, BYTE);
  localparam int unsigned DEPTH = 2 ** ADDR;

  logic [DATA-1:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;
  logic            clearing;

  logic            a_acc, b_acc, a_wact, b_wact, same_addr;
  logic [NBE-1:0]  a_lanes, b_lanes;
  logic [ADDR-1:0] wa_addr;
  logic [NBE-1:0]  wa_lanes;
  logic [DATA-1:0] wa_data;

  logic            a_acc_q, b_acc_q, a_wact_q, b_wact_q, coll_q;
  logic [NBE-1:0]  a_lanes_q, b_lanes_q, a_xlanes_q, b_xlanes_q;
  logic [DATA-1:0] a_din_q, b_din_q, a_old_q, b_old_q;
  logic [DATA-1:0] a_final, b_final, a_word, b_word;
  logic            a_hold, b_hold;

  // Clear sweep sequencing and state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? StClear : StReady;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: advance the sweep address, leave CLEAR after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = StReady;
      end
      StReady: ;
    endcase
  end

  assign clearing  = (state_q == StClear);
  assign init_done = (state_q == StReady);

  // Request qualification; a write with no lanes enabled behaves as a read.
  always_comb begin
    a_acc     = rst_n & ~clearing & a_en;
    b_acc     = rst_n & ~clearing & b_en;
    a_wact    = a_acc & a_wr & (|a_be);
    b_wact    = b_acc & b_wr & (|b_be);
    same_addr = (a_addr == b_addr);
    a_lanes   = a_wact ? a_be : '0;
    // Port A owns any lane both ports write at the same address.
    b_lanes   = (b_wact ? b_be : '0) & ~(same_addr ? a_lanes : '0);
    // The sweep borrows port A's write path.
    wa_addr   = clearing ? cnt_q : a_addr;
    wa_lanes  = clearing ? {NBE{rst_n}} : a_lanes;
    wa_data   = clearing ? '0 : a_din;
  end

  // Storage array: byte-lane writes on both ports, read-first registered reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBE; i++) begin
      if (wa_lanes[i]) mem[wa_addr][i*BYTE +: BYTE] <= wa_data[i*BYTE +: BYTE];
      if (b_lanes[i])  mem[b_addr][i*BYTE +: BYTE]  <= b_din[i*BYTE +: BYTE];
    end
    a_old_q <= mem[a_addr];
    b_old_q <= mem[b_addr];
  end

  // Access tracking and collision pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_acc_q <= 1'b0;
      b_acc_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      a_acc_q <= a_acc;
      b_acc_q <= b_acc;
      coll_q  <= a_acc & b_acc & same_addr & (a_wact | b_wact);
    end
  end

  // Write context needed to rebuild the stored word alongside the read data.
  always_ff @(posedge clk) begin
    a_wact_q   <= a_wact;
    b_wact_q   <= b_wact;
    a_lanes_q  <= a_lanes;
    b_lanes_q  <= b_lanes;
    a_xlanes_q <= same_addr ? b_lanes : '0;
    b_xlanes_q <= same_addr ? a_lanes : '0;
    a_din_q    <= a_din;
    b_din_q    <= b_din;
  end

  // Final stored word as seen from each port, then per-mode selection.
  always_comb begin
    a_final = a_old_q;
    b_final = b_old_q;
    for (int i = 0; i < NBE; i++) begin
      if (a_lanes_q[i])       a_final[i*BYTE +: BYTE] = a_din_q[i*BYTE +: BYTE];
      else if (a_xlanes_q[i]) a_final[i*BYTE +: BYTE] = b_din_q[i*BYTE +: BYTE];
      if (b_xlanes_q[i])      b_final[i*BYTE +: BYTE] = a_din_q[i*BYTE +: BYTE];
      else if (b_lanes_q[i])  b_final[i*BYTE +: BYTE] = b_din_q[i*BYTE +: BYTE];
    end
    // Readers always see the pre-write word; only a writer may see its merged result.
    a_word = (a_wact_q && RDW_MODE == RDW_WRITE_FIRST) ? a_final : a_old_q;
    b_word = (b_wact_q && RDW_MODE == RDW_WRITE_FIRST) ? b_final : b_old_q;
    a_hold = a_wact_q && (RDW_MODE == RDW_NO_CHANGE);
    b_hold = b_wact_q && (RDW_MODE == RDW_NO_CHANGE);
  end

  assign collision = coll_q;

  bram_port_out #(
    .DATA    (DATA),
    .OUT_REG (OUT_REG)
  ) u_out_a (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (a_acc_q),
    .hold  (a_hold),
    .word  (a_word),
    .dout  (a_dout),
    .valid (a_valid)
  );

  bram_port_out #(
    .DATA    (DATA),
    .OUT_REG (OUT_REG)
  ) u_out_b (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (b_acc_q),
    .hold  (b_hold),
    .word  (b_word),
    .dout  (b_dout),
    .valid (b_valid)
  );

endmodule

// File: tb/tb_bram_tdp_be.sv
// Directed bench: four instances share stimulus (WRITE_FIRST, READ_FIRST,
// NO_CHANGE, and WRITE_FIRST with output register).
module tb_bram_tdp_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_wr, b_en, b_wr;
  logic [3:0]  a_be, b_be, a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic [31:0] a_dout [4];
  logic [31:0] b_dout [4];
  logic [3:0]  a_valid, b_valid, coll, init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_tdp_be #(.DATA(32), .ADDR(4), .BYTE(8), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1))
  u0 (.clk(clk), .rst_n(rst_n), .init_done(init_done[0]),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout[0]), .a_valid(a_valid[0]),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
      .b_dout(b_dout[0]), .b_valid(b_valid[0]), .collision(coll[0]));

  bram_tdp_be #(.DATA(32), .ADDR(4), .BYTE(8), .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1))
  u1 (.clk(clk), .rst_n(rst_n), .init_done(init_done[1]),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout[1]), .a_valid(a_valid[1]),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
      .b_dout(b_dout[1]), .b_valid(b_valid[1]), .collision(coll[1]));

  bram_tdp_be #(.DATA(32), .ADDR(4), .BYTE(8), .RDW_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1))
  u2 (.clk(clk), .rst_n(rst_n), .init_done(init_done[2]),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout[2]), .a_valid(a_valid[2]),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
      .b_dout(b_dout[2]), .b_valid(b_valid[2]), .collision(coll[2]));

  bram_tdp_be #(.DATA(32), .ADDR(4), .BYTE(8), .RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1))
  u3 (.clk(clk), .rst_n(rst_n), .init_done(init_done[3]),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout[3]), .a_valid(a_valid[3]),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
      .b_dout(b_dout[3]), .b_valid(b_valid[3]), .collision(coll[3]));

  typedef struct {
    logic        ae, aw;
    logic [3:0]  abe, aad;
    logic [31:0] adin;
    logic        be, bw;
    logic [3:0]  bbe, bad;
    logic [31:0] bdin;
    logic [31:0] ea;
    logic        eav;
    logic [31:0] eb;
    logic        ebv;
    logic        ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ae, input logic aw, input logic [3:0] abe, input logic [3:0] aad,
    input logic [31:0] adin,
    input logic be, input logic bw, input logic [3:0] bbe, input logic [3:0] bad,
    input logic [31:0] bdin,
    input logic [31:0] ea, input logic eav, input logic [31:0] eb, input logic ebv,
    input logic ec);
    vec_t v;
    v.ae = ae; v.aw = aw; v.abe = abe; v.aad = aad; v.adin = adin;
    v.be = be; v.bw = bw; v.bbe = bbe; v.bad = bad; v.bdin = bdin;
    v.ea = ea; v.eav = eav; v.eb = eb; v.ebv = ebv; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_en = v.ae; a_wr = v.aw; a_be = v.abe; a_addr = v.aad; a_din = v.adin;
    b_en = v.be; b_wr = v.bw; b_be = v.bbe; b_addr = v.bad; b_din = v.bdin;
  endtask

  task automatic idle();
    a_en = 0; a_wr = 0; a_be = 0; a_addr = 0; a_din = 0;
    b_en = 0; b_wr = 0; b_be = 0; b_addr = 0; b_din = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until init_done rises; also checks reads stay invalid during the sweep.
  task automatic wait_init(output int n);
    n = 0;
    while (init_done[0] == 1'b0 && n < 100) begin
      step();
      n++;
      if (init_done[0] == 1'b0) chk("valid during clear", 32'(a_valid[0]), 32'd0);
    end
  endtask

  initial begin
    int n;

    // Table for the WRITE_FIRST / OUT_REG=0 instance.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, 0, 4'h0, 4'(i), 0, 1, 0, 4'h0, 4'(15 - i), 0,
                        32'h0, 1, 32'h0, 1, 0));
    vecs.push_back(mk(1, 1, 4'b0101, 4'd3, 32'hAABBCCDD, 0, 0, 0, 0, 0,
                      32'h00BB00DD, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd3, 0, 0, 0, 0, 0, 0,
                      32'h00BB00DD, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 1, 4'b0011, 4'd7, 32'hAAAAAAAA, 1, 1, 4'b0110, 4'd7, 32'hBBBBBBBB,
                      32'h00BBAAAA, 1, 32'h00BBAAAA, 1, 1));
    vecs.push_back(mk(1, 0, 0, 4'd7, 0, 0, 0, 0, 0, 0,
                      32'h00BBAAAA, 1, 32'h00BBAAAA, 0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 4'd9, 32'h12345678, 0, 0, 0, 0, 0,
                      32'h12345678, 1, 32'h00BBAAAA, 0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 4'd9, 32'hDEADBEEF, 1, 0, 0, 4'd9, 0,
                      32'hDEADBEEF, 1, 32'h12345678, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 4'd9, 0,
                      32'hDEADBEEF, 0, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(1, 1, 4'hF, 4'd15, 32'hCAFEF00D, 1, 0, 0, 4'd0, 0,
                      32'hCAFEF00D, 1, 32'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'd15, 0, 1, 1, 4'h0, 4'd15, 32'hFFFFFFFF,
                      32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'd3, 0, 1, 1, 4'b1000, 4'd2, 32'h5A000000,
                      32'h00BB00DD, 1, 32'h5A000000, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'd2, 0, 1, 0, 0, 4'd2, 0,
                      32'h5A000000, 1, 32'h5A000000, 1, 0));
    vecs.push_back(mk(1, 1, 4'h0, 4'd11, 32'hFFFFFFFF, 1, 1, 4'hF, 4'd11, 32'h77777777,
                      32'h0, 1, 32'h77777777, 1, 1));

    // Reset and initial sweep.
    idle();
    rst_n = 0;
    step();
    step();
    chk("reset a_dout", a_dout[0], 32'h0);
    chk("reset a_valid", 32'(a_valid[0]), 32'd0);
    chk("reset b_valid", 32'(b_valid[0]), 32'd0);
    chk("reset collision", 32'(coll[0]), 32'd0);
    chk("reset init_done", 32'(init_done[0]), 32'd0);
    rst_n = 1;
    wait_init(n);
    chk("sweep length", 32'(n), 32'd16);

    // Table-driven main function.
    foreach (vecs[k]) begin
      drive(vecs[k]);
      step();
      chk($sformatf("v%0d a_dout", k), a_dout[0], vecs[k].ea);
      chk($sformatf("v%0d a_valid", k), 32'(a_valid[0]), 32'(vecs[k].eav));
      chk($sformatf("v%0d b_dout", k), b_dout[0], vecs[k].eb);
      chk($sformatf("v%0d b_valid", k), 32'(b_valid[0]), 32'(vecs[k].ebv));
      chk($sformatf("v%0d collision", k), 32'(coll[0]), 32'(vecs[k].ec));
    end

    // Read-during-write modes on address 5.
    idle(); a_en = 1; a_addr = 4'd4;
    step();
    for (int m = 0; m < 3; m++) chk($sformatf("rdw%0d prime", m), a_dout[m], 32'h0);
    a_wr = 1; a_be = 4'hF; a_addr = 4'd5; a_din = 32'h11111111;
    step();
    chk("wf first", a_dout[0], 32'h11111111);
    chk("rf first", a_dout[1], 32'h0);
    chk("nc first", a_dout[2], 32'h0);
    chk("nc first valid", 32'(a_valid[2]), 32'd0);
    a_din = 32'h22222222;
    step();
    chk("wf dout", a_dout[0], 32'h22222222);
    chk("rf dout", a_dout[1], 32'h11111111);
    chk("rf valid", 32'(a_valid[1]), 32'd1);
    chk("nc dout", a_dout[2], 32'h0);
    chk("nc valid", 32'(a_valid[2]), 32'd0);
    a_wr = 0; a_be = 0;
    step();
    for (int m = 0; m < 3; m++) chk($sformatf("rdw%0d readback", m), a_dout[m], 32'h22222222);

    // Output-register latency.
    idle();
    step();
    a_en = 1; a_addr = 4'd3;
    step();
    chk("outreg t+1 valid", 32'(a_valid[3]), 32'd0);
    chk("noreg t+1 data", a_dout[0], 32'h00BB00DD);
    idle();
    step();
    chk("outreg t+2 valid", 32'(a_valid[3]), 32'd1);
    chk("outreg t+2 data", a_dout[3], 32'h00BB00DD);
    step();
    chk("outreg t+3 valid", 32'(a_valid[3]), 32'd0);
    chk("outreg hold", a_dout[3], 32'h00BB00DD);

    // Reset in the middle of a sweep.
    rst_n = 0;
    step();
    chk("mid reset outreg dout", a_dout[3], 32'h0);
    rst_n = 1;
    repeat (6) step();
    chk("mid sweep init_done", 32'(init_done[0]), 32'd0);
    rst_n = 0;
    step();
    chk("restart init_done", 32'(init_done[0]), 32'd0);
    rst_n = 1;
    a_en = 1; a_addr = 4'd15;
    wait_init(n);
    chk("restart sweep length", 32'(n), 32'd16);
    b_en = 1; b_addr = 4'd9;
    step();
    chk("cleared a valid", 32'(a_valid[0]), 32'd1);
    chk("cleared a data", a_dout[0], 32'h0);
    chk("cleared b valid", 32'(b_valid[0]), 32'd1);
    chk("cleared b data", b_dout[0], 32'h0);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
